// File: rtl/issue_scheduler_if.sv
// Decoded-pair payload type and the scheduler's decode-queue / execute-pipe interface.
// master = scheduler side, slave = queue/execute side.
package issue_scheduler_pkg;
  localparam int unsigned REG_W = 5;
  localparam int unsigned TAG_W = 8;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [REG_W-1:0] rd_addr;
    logic             rd_wren;
    logic [REG_W-1:0] rs1_addr;
    logic             rs1_en;
    logic [REG_W-1:0] rs2_addr;
    logic             rs2_en;
    logic             is_mem;
  } decode_t;
endpackage

interface issue_scheduler_if;
  import issue_scheduler_pkg::*;

  logic          flush;
  logic          dque_sch_ready;
  logic          dque_sch_ack;
  decode_t [1:0] decode;
  logic          sch_dque_request;
  logic          exe_stall;
  decode_t [1:0] issue;
  logic    [1:0] issue_valid;

  modport master (
    input  flush, dque_sch_ready, dque_sch_ack, decode, exe_stall,
    output sch_dque_request, issue, issue_valid
  );

  modport slave (
    output flush, dque_sch_ready, dque_sch_ack, decode, exe_stall,
    input  sch_dque_request, issue, issue_valid
  );
endinterface

// File: rtl/issue_scheduler.sv
// Dual-issue scheduler: pops one decoded pair per handshake and issues it, splitting on hazards.
// Optional performance counters enabled by defining SCHED_PERF_CNT_EN.
module issue_scheduler
  import issue_scheduler_pkg::*;
#(
  parameter int unsigned MEM_PORTS = 1,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
`ifdef SCHED_PERF_CNT_EN
  output logic [CNT_W-1:0] o_cnt_dual,
  output logic [CNT_W-1:0] o_cnt_split,
`endif
  issue_scheduler_if.master sch
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_PAIR  = 2'd1,
    S_SLOT1 = 2'd2
  } state_t;

  state_t        state_q, state_d;
  decode_t [1:0] hold_q;
  logic          raw, waw, mem_conflict, hazard, dual;
  logic          free, request, capture;
  logic [1:0]    issue_valid;

  // Slot 1 dependencies on slot 0 within the held pair
  always_comb begin
    raw = hold_q[0].rd_wren && (hold_q[0].rd_addr != '0) &&
          ((hold_q[1].rs1_en && (hold_q[1].rs1_addr == hold_q[0].rd_addr)) ||
           (hold_q[1].rs2_en && (hold_q[1].rs2_addr == hold_q[0].rd_addr)));
    waw = hold_q[0].rd_wren && hold_q[1].rd_wren && (hold_q[0].rd_addr != '0) &&
          (hold_q[0].rd_addr == hold_q[1].rd_addr);
    mem_conflict = hold_q[0].is_mem && hold_q[1].is_mem && (MEM_PORTS == 1);
    hazard = hold_q[0].valid && hold_q[1].valid && (raw || waw || mem_conflict);
    dual   = !hazard;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (sch.flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: if (capture) state_d = S_PAIR;
        S_PAIR: begin
          if (!sch.exe_stall) begin
            if (hazard)       state_d = S_SLOT1;
            else if (capture) state_d = S_PAIR;
            else              state_d = S_EMPTY;
          end
        end
        S_SLOT1: begin
          if (!sch.exe_stall) state_d = capture ? S_PAIR : S_EMPTY;
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  // A new pair may be taken whenever the held one is gone or retires this cycle
  always_comb begin
    issue_valid = 2'b00;
    free        = 1'b0;
    case (state_q)
      S_EMPTY: free = 1'b1;
      S_PAIR: begin
        issue_valid = {dual & hold_q[1].valid, hold_q[0].valid};
        free        = dual & ~sch.exe_stall;
      end
      S_SLOT1: begin
        issue_valid = {hold_q[1].valid, 1'b0};
        free        = ~sch.exe_stall;
      end
      default: ;
    endcase
    request = free & sch.dque_sch_ready & ~sch.flush & ~i_rst;
    capture = request & sch.dque_sch_ack;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || sch.flush) hold_q <= '0;
    else if (capture)       hold_q <= sch.decode;
  end

  assign sch.sch_dque_request = request;
  assign sch.issue            = hold_q;
  assign sch.issue_valid      = issue_valid;

`ifdef SCHED_PERF_CNT_EN
  logic dual_fire, split_fire;

  assign dual_fire  = (issue_valid == 2'b11) && !sch.exe_stall && !sch.flush;
  assign split_fire = (state_q == S_PAIR) && hazard && !sch.exe_stall && !sch.flush;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_cnt_dual  <= '0;
      o_cnt_split <= '0;
    end else begin
      if (dual_fire)  o_cnt_dual  <= o_cnt_dual + CNT_W'(1);
      if (split_fire) o_cnt_split <= o_cnt_split + CNT_W'(1);
    end
  end
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_issue_scheduler.sv
// Bench for issue_scheduler: MEM_PORTS=1 and MEM_PORTS=2 instances on a shared decode-queue stream,
// checked every cycle against a pair-level model plus directed literal expectations.
module tb_issue_scheduler;
  import issue_scheduler_pkg::*;

  logic clk = 1'b0;
  logic rst, flush, stall, ready_en, ack_en, ack_force, ack_now;
  decode_t [1:0] prog [0:31];
  logic [4:0] ptr = 5'd0;
  logic [4:0] nprog;
  int n_chk = 0;
  int n_err = 0;

  issue_scheduler_if ifa ();
  issue_scheduler_if ifb ();

`ifdef SCHED_PERF_CNT_EN
  logic [31:0] cnt_dual_a, cnt_split_a, cnt_dual_b, cnt_split_b;
`endif

  issue_scheduler #(.MEM_PORTS(1), .CNT_W(32)) dut_a (
    .i_clk(clk), .i_rst(rst),
`ifdef SCHED_PERF_CNT_EN
    .o_cnt_dual(cnt_dual_a), .o_cnt_split(cnt_split_a),
`endif
    .sch(ifa)
  );

  issue_scheduler #(.MEM_PORTS(2), .CNT_W(32)) dut_b (
    .i_clk(clk), .i_rst(rst),
`ifdef SCHED_PERF_CNT_EN
    .o_cnt_dual(cnt_dual_b), .o_cnt_split(cnt_split_b),
`endif
    .sch(ifb)
  );

  always #5 clk = ~clk;

  // Decode queue emulation, popped by instance A's handshake (plus forced stray acks)
  always_comb begin
    ack_now = (ack_en & ifa.sch_dque_request) | ack_force;
    ifa.dque_sch_ready = ready_en && (ptr != nprog);
    ifa.decode         = (ptr != nprog) ? prog[ptr] : '0;
    ifa.dque_sch_ack   = ack_now;
    ifa.flush          = flush;
    ifa.exe_stall      = stall;
    ifb.dque_sch_ready = ifa.dque_sch_ready;
    ifb.decode         = ifa.decode;
    ifb.dque_sch_ack   = ack_now;
    ifb.flush          = flush;
    ifb.exe_stall      = stall;
  end

  always @(posedge clk) if (ack_now && (ptr != nprog)) ptr <= ptr + 5'd1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic decode_t mk(input int tag, input int rd, input int rs1, input int rs2,
                                 input bit wren, input bit mem, input bit rs2en);
    decode_t d;
    d.valid = 1'b1;      d.tag = 8'(tag);
    d.rd_addr = 5'(rd);  d.rd_wren = wren;
    d.rs1_addr = 5'(rs1); d.rs1_en = 1'b1;
    d.rs2_addr = 5'(rs2); d.rs2_en = rs2en;
    d.is_mem = mem;
    return d;
  endfunction

  task automatic add_pair(input decode_t s0, input decode_t s1);
    prog[nprog][0] = s0;
    prog[nprog][1] = s1;
    nprog = nprog + 5'd1;
  endtask

  // True when the two slots of a pair may go out together
  function automatic bit independent(input decode_t [1:0] p, input int mp);
    bit w0;
    if (!(p[0].valid && p[1].valid)) return 1'b1;
    w0 = p[0].rd_wren && (p[0].rd_addr != 0);
    if (w0 && ((p[1].rs1_en && p[1].rs1_addr == p[0].rd_addr) ||
               (p[1].rs2_en && p[1].rs2_addr == p[0].rd_addr))) return 1'b0;
    if (w0 && p[1].rd_wren && (p[1].rd_addr == p[0].rd_addr)) return 1'b0;
    if (mp == 1 && p[0].is_mem && p[1].is_mem) return 1'b0;
    return 1'b1;
  endfunction

  // Model: a held pair, whether slot 0 has already gone, and issue counts
  bit            m_busy [2];
  bit            m_done0 [2];
  decode_t [1:0] m_pair [2];
  int            m_dual [2];
  int            m_split [2];

  logic [1:0]    act_valid [2];
  logic          act_req [2];
  decode_t [1:0] act_issue [2];
  logic [31:0]   act_cd [2];
  logic [31:0]   act_cs [2];

  always_comb begin
    act_valid[0] = ifa.issue_valid;      act_valid[1] = ifb.issue_valid;
    act_req[0]   = ifa.sch_dque_request; act_req[1]   = ifb.sch_dque_request;
    act_issue[0] = ifa.issue;            act_issue[1] = ifb.issue;
`ifdef SCHED_PERF_CNT_EN
    act_cd[0] = cnt_dual_a;  act_cs[0] = cnt_split_a;
    act_cd[1] = cnt_dual_b;  act_cs[1] = cnt_split_b;
`else
    act_cd[0] = 32'd0; act_cs[0] = 32'd0; act_cd[1] = 32'd0; act_cs[1] = 32'd0;
`endif
  end

  initial begin
    logic [1:0] ev;
    bit ind, ret, spl, er;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        ind = independent(m_pair[d], (d == 0) ? 1 : 2);
        if (!m_busy[d])      ev = 2'b00;
        else if (m_done0[d]) ev = {m_pair[d][1].valid, 1'b0};
        else                 ev = {ind ? m_pair[d][1].valid : 1'b0, m_pair[d][0].valid};
        ret = m_busy[d] && !stall && (m_done0[d] || ind);
        spl = m_busy[d] && !m_done0[d] && !ind && !stall;
        er  = (!m_busy[d] || ret) && ifa.dque_sch_ready && !flush && !rst;
        chk($sformatf("d%0d_valid", d), 64'(act_valid[d]), 64'(ev));
        chk($sformatf("d%0d_issue", d), 64'(act_issue[d]), 64'(m_pair[d]));
        chk($sformatf("d%0d_request", d), 64'(act_req[d]), 64'(er));
`ifdef SCHED_PERF_CNT_EN
        chk($sformatf("d%0d_cnt_dual", d), 64'(act_cd[d]), 64'(32'(m_dual[d])));
        chk($sformatf("d%0d_cnt_split", d), 64'(act_cs[d]), 64'(32'(m_split[d])));
`endif
        if (rst) begin
          m_busy[d] = 0; m_done0[d] = 0; m_pair[d] = '0; m_dual[d] = 0; m_split[d] = 0;
        end else if (flush) begin
          m_busy[d] = 0; m_done0[d] = 0; m_pair[d] = '0;
        end else begin
          if (ev == 2'b11 && !stall) m_dual[d]++;
          if (spl) begin m_split[d]++; m_done0[d] = 1; end
          if (ret || !m_busy[d]) begin
            if (er && ack_now) begin
              m_pair[d] = ifa.decode; m_busy[d] = 1; m_done0[d] = 0;
            end else begin
              m_busy[d] = 0;
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input logic [1:0] v, input string nm);
    bit got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (ifa.issue_valid == v) got = 1'b1;
    end
    chk(nm, 64'(got), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    decode_t inv;
    rst = 1'b1; flush = 1'b0; stall = 1'b0;
    ready_en = 1'b1; ack_en = 1'b1; ack_force = 1'b0; nprog = 5'd0;
    for (int i = 0; i < 4; i++)
      add_pair(mk(2*i+1, 6*i+1, 6*i+2, 6*i+3, 1, 0, 1), mk(2*i+2, 6*i+4, 6*i+5, 6*i+6, 1, 0, 1));
    add_pair(mk(9, 5, 1, 2, 1, 0, 1),  mk(10, 6, 5, 3, 1, 0, 1));
    add_pair(mk(11, 0, 1, 2, 1, 0, 1), mk(12, 6, 0, 3, 1, 0, 1));
    add_pair(mk(13, 7, 1, 0, 1, 1, 0), mk(14, 8, 2, 0, 1, 1, 0));

    repeat (2) begin
      @(negedge clk);
      chk("rst_request", 64'(ifa.sch_dque_request), 64'd0);
      chk("rst_valid", 64'(ifa.issue_valid), 64'd0);
    end
    step(); rst = 1'b0;
    @(negedge clk);
    chk("first_request", 64'(ifa.sch_dque_request), 64'd1);
    chk("first_empty", 64'(ifa.issue_valid), 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stream_valid", 64'(ifa.issue_valid), 64'd3);
      chk("stream_tag", 64'(ifa.issue[0].tag), 64'(2*i+1));
    end
    @(negedge clk);
    chk("raw_slot0", 64'(ifa.issue_valid), 64'd1);
    chk("raw_no_pop", 64'(ifa.sch_dque_request), 64'd0);
    @(negedge clk);
    chk("raw_slot1", 64'(ifa.issue_valid), 64'd2);
    chk("raw_slot1_tag", 64'(ifa.issue[1].tag), 64'd10);
`ifdef SCHED_PERF_CNT_EN
    chk("cnt_dual_lit", 64'(cnt_dual_a), 64'd4);
    chk("cnt_split_lit", 64'(cnt_split_a), 64'd1);
`endif
    @(negedge clk);
    chk("x0_dual", 64'(ifa.issue_valid), 64'd3);
    @(negedge clk);
    chk("mem1_slot0", 64'(ifa.issue_valid), 64'd1);
    chk("mem2_dual", 64'(ifb.issue_valid), 64'd3);
    @(negedge clk);
    chk("mem1_slot1", 64'(ifa.issue_valid), 64'd2);

    // Stall in PAIR, a stray ack, then a slot0-invalid and an all-invalid pair
    step();
    for (int i = 0; i < 3; i++)
      add_pair(mk(15+2*i, 1, 2, 3, 1, 0, 1), mk(16+2*i, 4, 5, 6, 1, 0, 1));
    inv = mk(21, 1, 2, 3, 1, 0, 1); inv.valid = 1'b0;
    add_pair(inv, mk(22, 4, 5, 6, 1, 0, 1));
    inv = mk(23, 1, 2, 3, 1, 0, 1); inv.valid = 1'b0;
    add_pair(inv, '0);
    prog[nprog-5'd1][1].tag = 8'd24;
    wait_valid(2'b11, "stall_wait");
    step(); stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid", 64'(ifa.issue_valid), 64'd3);
      chk("stall_tag", 64'(ifa.issue[0].tag), 64'd17);
      chk("stall_no_pop", 64'(ifa.sch_dque_request), 64'd0);
      step();
      ack_force = (i == 0);
      if (i == 2) stall = 1'b0;
    end
    @(negedge clk);
    chk("resume_tag", 64'(ifa.issue[0].tag), 64'd17);
    @(negedge clk);
    chk("slot1_only_valid", 64'(ifa.issue_valid), 64'd2);
    chk("slot1_only_tag", 64'(ifa.issue[1].tag), 64'd22);
    @(negedge clk);
    chk("empty_pair_valid", 64'(ifa.issue_valid), 64'd0);

    // Request without ack must not capture
    step(); ack_en = 1'b0;
    add_pair(mk(25, 1, 2, 3, 1, 0, 1), mk(26, 4, 5, 6, 1, 0, 1));
    @(negedge clk);
    chk("noack_request", 64'(ifa.sch_dque_request), 64'd1);
    step();
    @(negedge clk);
    chk("noack_nocapture", 64'(ifa.issue_valid), 64'd0);
    step(); ack_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("ack_capture_tag", 64'(ifa.issue[0].tag), 64'd25);

    // Flush while in SLOT1
    step();
    add_pair(mk(27, 3, 1, 2, 1, 0, 1), mk(28, 9, 3, 3, 1, 0, 1));
    add_pair(mk(29, 1, 2, 3, 1, 0, 1), mk(30, 4, 5, 6, 1, 0, 1));
    wait_valid(2'b01, "flush_wait");
    step(); flush = 1'b1;
    @(negedge clk);
    chk("flush_slot1_valid", 64'(ifa.issue_valid), 64'd2);
    chk("flush_no_pop", 64'(ifa.sch_dque_request), 64'd0);
    step(); flush = 1'b0;
    @(negedge clk);
    chk("post_flush_valid", 64'(ifa.issue_valid), 64'd0);
    chk("post_flush_issue", 64'(ifa.issue), 64'd0);
    @(negedge clk);
    chk("post_flush_next", 64'(ifa.issue[0].tag), 64'd29);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
